// File: rtl/mult_booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier (operand width,
// iteration count and FSM state encoding).
package mult_pkg;

    localparam int WIDTH      = 32;
    localparam int ITERATIONS = WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/mult_booth_if.sv
// Control-unit <-> multiplier bus: operands and start/abort in, product halves
// and status out. The control unit is the master.
interface mult_booth_if #(
    parameter int WIDTH = mult_pkg::WIDTH
) ();

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             init;
    logic             stop;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output a, b, init, stop,
        input  hi, lo, busy, done
    );

    modport slave (
        input  a, b, init, stop,
        output hi, lo, busy, done
    );

endinterface

// File: rtl/mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into the
// WIDTH+1-bit accumulator, then arithmetic right shift of {A,Q,q_1}.
module booth_step #(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);

    logic [WIDTH:0] sum;

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        sum = acc_i;
        case ({q_i[0], q1_i})
            2'b01:   sum = acc_i + m_i;
            2'b10:   sum = acc_i - m_i;
            default: sum = acc_i;
        endcase
        acc_o = {sum[WIDTH], sum[WIDTH:1]};
        q_o   = {sum[0], q_i[WIDTH-1:1]};
        q1_o  = q_i[0];
    end

endmodule

// File: rtl/mult_booth.sv
// Sequential signed WIDTH x WIDTH radix-2 Booth multiplier, one step per clock.
// Optional MULT_BOOTH_ZERO_SKIP_EN: a zero operand finishes in a single cycle.
module mult_booth
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    mult_booth_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q1_q, q1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   acc_nx;
    logic [WIDTH-1:0] q_nx;
    logic             q1_nx;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .q1_i  (q1_q),
        .m_i   (m_q),
        .acc_o (acc_nx),
        .q_o   (q_nx),
        .q1_o  (q1_nx)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // stop outranks init, so a simultaneous abort starts nothing
                if (bus.init && !bus.stop) begin
                    m_d    = {bus.a[WIDTH-1], bus.a};
                    acc_d  = '0;
                    q_d    = bus.b;
                    q1_d   = 1'b0;
                    cnt_d  = CNT_W'(WIDTH);
                    busy_d = 1'b1;
`ifdef MULT_BOOTH_ZERO_SKIP_EN
                    if (bus.a == '0 || bus.b == '0) begin
                        q_d     = '0;
                        state_d = FIN;
                    end else begin
                        state_d = RUN;
                    end
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                if (bus.stop) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    acc_d = acc_nx;
                    q_d   = q_nx;
                    q1_d  = q1_nx;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (!bus.stop) begin
                    hi_d   = acc_q[WIDTH-1:0];
                    lo_d   = q_q;
                    done_d = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
